// File: rtl/multi_issue_fifo.sv
// Multi-issue circular queue: up to ENQ_W sparse lanes compacted in per cycle,
// oldest DEQ_W entries presented in order, 0..DEQ_W retired per cycle.
`ifndef DECODE_DATA_WIDTH
`define DECODE_DATA_WIDTH 32
`endif

module multi_issue_fifo #(
    parameter int DATA_W     = `DECODE_DATA_WIDTH,
    parameter int DEPTH      = 16,
    parameter int ENQ_W      = 2,
    parameter int DEQ_W      = 2,
    parameter int REQ_THRESH = ENQ_W + 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush,
    input  logic [ENQ_W-1:0]              enqueue_en,
    input  logic [ENQ_W*DATA_W-1:0]       enqueue_data,
    output logic                          enq_ready,
    output logic [DEQ_W-1:0]              dequeue_valid,
    output logic [DEQ_W*DATA_W-1:0]       dequeue_data,
    input  logic [$clog2(DEQ_W+1)-1:0]    deq_num,
    output logic [$clog2(DEPTH+1)-1:0]    count,
    output logic                          get_data_req,
    output logic                          full,
    output logic                          empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int CW = $clog2(DEPTH+1);
    localparam int EW = $clog2(ENQ_W+1);
    localparam logic [31:0] ENQ_W_U  = 32'(ENQ_W);
    localparam logic [31:0] THRESH_U = 32'(REQ_THRESH);

    logic [PW-1:0]     r_head;
    logic [PW-1:0]     r_tail;
    logic [DATA_W-1:0] r_ram [DEPTH];

    logic [PW-1:0]     w_count;
    logic [PW-1:0]     w_free;
    logic [PW-1:0]     w_deq_req;
    logic [PW-1:0]     w_pop;
    logic [EW-1:0]     w_enq_k;
    logic [ENQ_W-1:0]  w_wr_en;
    logic [AW-1:0]     w_wr_idx [ENQ_W];
    logic              w_do_enq;

    // Status is a pure function of the registered pointers.
    assign w_count      = r_tail - r_head;
    assign w_free       = PW'(DEPTH) - w_count;
    assign count        = CW'(w_count);
    assign full         = (w_count == PW'(DEPTH));
    assign empty        = (w_count == '0);
    assign enq_ready    = (32'(w_free) >= ENQ_W_U);
    assign get_data_req = (32'(w_free) >= THRESH_U);

    // Over-pop is clamped to the current occupancy.
    assign w_deq_req = PW'(deq_num);
    assign w_pop     = (w_deq_req > w_count) ? w_count : w_deq_req;

    assign w_do_enq = rst && !flush && enq_ready;

    always_comb begin
        dequeue_valid = '0;
        dequeue_data  = '0;
        for (int i = 0; i < DEQ_W; i++) begin
            dequeue_valid[i]               = (32'(w_count) > 32'(i));
            dequeue_data[i*DATA_W +: DATA_W] = r_ram[r_head[AW-1:0] + AW'(i)];
        end
    end

    // Lane compaction: the j-th set lane lands at tail+j.
    always_comb begin
        w_enq_k = '0;
        for (int i = 0; i < ENQ_W; i++) begin
            w_wr_en[i]  = enqueue_en[i];
            w_wr_idx[i] = r_tail[AW-1:0] + AW'(w_enq_k);
            // NOTE: blocking '=' here is intentional: the running lane offset
            // must be visible to the next iteration within the same evaluation.
            w_enq_k     = w_enq_k + EW'(enqueue_en[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_head <= '0;
            r_tail <= '0;
        end else if (flush) begin
            r_head <= '0;
            r_tail <= '0;
        end else begin
            r_head <= r_head + w_pop;
            if (enq_ready) begin
                r_tail <= r_tail + PW'(w_enq_k);
            end
        end
    end

    // NOTE: storage array deliberately has no reset; validity is tracked
    // entirely by the pointers, so clearing it would only cost logic.
    always_ff @(posedge clk) begin
        if (w_do_enq) begin
            for (int i = 0; i < ENQ_W; i++) begin
                if (w_wr_en[i]) begin
                    r_ram[w_wr_idx[i]] <= enqueue_data[i*DATA_W +: DATA_W];
                end
            end
        end
    end

endmodule

// File: tb/tb_multi_issue_fifo.sv
// Self-checking bench for multi_issue_fifo (DEPTH=8, 2-in/2-out, 8-bit data)
// against a queue-based reference model.
module tb_multi_issue_fifo;

    localparam int DW    = 8;
    localparam int DEPTH = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic [1:0]    enqueue_en;
    logic [2*DW-1:0] enqueue_data;
    logic          enq_ready;
    logic [1:0]    dequeue_valid;
    logic [2*DW-1:0] dequeue_data;
    logic [1:0]    deq_num;
    logic [3:0]    count;
    logic          get_data_req;
    logic          full;
    logic          empty;

    int errors = 0;
    int checks = 0;

    logic [DW-1:0] m_q[$];
    int            m_head;
    int            m_tail;

    multi_issue_fifo #(
        .DATA_W(DW), .DEPTH(DEPTH), .ENQ_W(2), .DEQ_W(2), .REQ_THRESH(3)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .enqueue_en(enqueue_en), .enqueue_data(enqueue_data),
        .enq_ready(enq_ready), .dequeue_valid(dequeue_valid),
        .dequeue_data(dequeue_data), .deq_num(deq_num), .count(count),
        .get_data_req(get_data_req), .full(full), .empty(empty)
    );

    always #5 clk = ~clk;

    // Drives one cycle of inputs, advances the model, samples 1 time unit after the edge.
    task automatic cycle(input logic r, input logic f, input logic [1:0] en,
                         input logic [2*DW-1:0] d, input logic [1:0] dn);
        int  sz;
        int  pop;
        bit  ok;
        rst = r; flush = f; enqueue_en = en; enqueue_data = d; deq_num = dn;
        sz = m_q.size();
        if (!r || f) begin
            m_q.delete();
            m_head = 0;
            m_tail = 0;
        end else begin
            ok  = (DEPTH - sz) >= 2;
            pop = (int'(dn) < sz) ? int'(dn) : sz;
            for (int i = 0; i < pop; i++) void'(m_q.pop_front());
            m_head = (m_head + pop) % 16;
            if (ok) begin
                for (int i = 0; i < 2; i++) begin
                    if (en[i]) begin
                        m_q.push_back(d[i*DW +: DW]);
                        m_tail = (m_tail + 1) % 16;
                    end
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        cycle(1'b0, 1'b0, 2'b11, {8'h22, 8'h11}, 2'd0);
        cycle(1'b0, 1'b0, 2'b11, {8'h22, 8'h11}, 2'd0);
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", count); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got=%b exp=1", empty); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got=%b exp=0", full); end
        checks++; if (enq_ready !== 1'b1) begin errors++; $display("FAIL reset_enq_ready got=%b exp=1", enq_ready); end
        checks++; if (get_data_req !== 1'b1) begin errors++; $display("FAIL reset_req got=%b exp=1", get_data_req); end
        checks++; if (dequeue_valid !== 2'b00) begin errors++; $display("FAIL reset_valid got=%b exp=00", dequeue_valid); end
    endtask

    task automatic test_sparse();
        cycle(1'b1, 1'b0, 2'b10, {8'h0B, 8'hEE}, 2'd0);
        checks++; if (count !== 4'd1) begin errors++; $display("FAIL sparse_count1 got=%0d exp=1", count); end
        checks++; if (dequeue_data[DW-1:0] !== 8'h0B) begin errors++; $display("FAIL sparse_lane0 got=%h exp=0b", dequeue_data[DW-1:0]); end
        checks++; if (dequeue_valid !== 2'b01) begin errors++; $display("FAIL sparse_valid1 got=%b exp=01", dequeue_valid); end
        cycle(1'b1, 1'b0, 2'b11, {8'h0D, 8'h0C}, 2'd0);
        checks++; if (count !== 4'd3) begin errors++; $display("FAIL sparse_count3 got=%0d exp=3", count); end
        checks++; if (dequeue_data !== {8'h0C, 8'h0B}) begin errors++; $display("FAIL sparse_lanes got=%h exp=0c0b", dequeue_data); end
    endtask

    task automatic test_fill_backpressure();
        cycle(1'b0, 1'b0, 2'b00, '0, 2'd0);
        cycle(1'b1, 1'b0, 2'b11, {8'h02, 8'h01}, 2'd0);
        cycle(1'b1, 1'b0, 2'b11, {8'h04, 8'h03}, 2'd0);
        cycle(1'b1, 1'b0, 2'b11, {8'h06, 8'h05}, 2'd0);
        checks++; if (count !== 4'd6) begin errors++; $display("FAIL fill_count6 got=%0d exp=6", count); end
        checks++; if (enq_ready !== 1'b1) begin errors++; $display("FAIL fill_ready6 got=%b exp=1", enq_ready); end
        checks++; if (get_data_req !== 1'b0) begin errors++; $display("FAIL fill_req6 got=%b exp=0", get_data_req); end
        cycle(1'b1, 1'b0, 2'b11, {8'h08, 8'h07}, 2'd0);
        checks++; if (full !== 1'b1) begin errors++; $display("FAIL fill_full got=%b exp=1", full); end
        checks++; if (enq_ready !== 1'b0) begin errors++; $display("FAIL fill_ready8 got=%b exp=0", enq_ready); end
        cycle(1'b1, 1'b0, 2'b11, {8'h0A, 8'h09}, 2'd0);
        checks++; if (count !== 4'd8) begin errors++; $display("FAIL fill_ignored got=%0d exp=8", count); end
        cycle(1'b1, 1'b0, 2'b11, {8'h0A, 8'h09}, 2'd2);
        checks++; if (count !== 4'd6) begin errors++; $display("FAIL fill_pop_count got=%0d exp=6", count); end
        checks++; if (dequeue_data !== {8'h04, 8'h03}) begin errors++; $display("FAIL fill_pop_lanes got=%h exp=0403", dequeue_data); end
        for (int k = 0; k < 3; k++) begin
            cycle(1'b1, 1'b0, 2'b00, '0, 2'd2);
            if (m_q.size() >= 2) begin
                checks++; if (dequeue_data !== {m_q[1], m_q[0]}) begin errors++; $display("FAIL fill_drain_lanes got=%h exp=%h%h", dequeue_data, m_q[1], m_q[0]); end
            end
        end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL fill_drained got=%b exp=1", empty); end
    endtask

    task automatic test_wrap();
        cycle(1'b0, 1'b0, 2'b00, '0, 2'd0);
        cycle(1'b1, 1'b0, 2'b11, {8'h31, 8'h30}, 2'd0);
        cycle(1'b1, 1'b0, 2'b11, {8'h33, 8'h32}, 2'd0);
        cycle(1'b1, 1'b0, 2'b11, {8'h35, 8'h34}, 2'd0);
        cycle(1'b1, 1'b0, 2'b01, {8'h00, 8'h36}, 2'd0);
        cycle(1'b1, 1'b0, 2'b00, '0, 2'd2);
        cycle(1'b1, 1'b0, 2'b00, '0, 2'd2);
        cycle(1'b1, 1'b0, 2'b00, '0, 2'd2);
        cycle(1'b1, 1'b0, 2'b00, '0, 2'd1);
        checks++; if (dut.r_head !== 4'(m_head) || dut.r_tail !== 4'(m_tail)) begin errors++; $display("FAIL wrap_ptrs7 got=%0d/%0d exp=%0d/%0d", dut.r_head, dut.r_tail, m_head, m_tail); end
        cycle(1'b1, 1'b0, 2'b11, {8'h02, 8'h01}, 2'd0);
        checks++; if (dequeue_data !== {8'h02, 8'h01}) begin errors++; $display("FAIL wrap_lanes got=%h exp=0201", dequeue_data); end
        checks++; if (dut.r_ram[7] !== 8'h01 || dut.r_ram[0] !== 8'h02) begin errors++; $display("FAIL wrap_ram got=%h,%h exp=01,02", dut.r_ram[7], dut.r_ram[0]); end
        cycle(1'b1, 1'b0, 2'b00, '0, 2'd2);
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL wrap_empty got=%b exp=1", empty); end
        checks++; if (dut.r_head !== 4'd9 || dut.r_tail !== 4'd9) begin errors++; $display("FAIL wrap_ptrs9 got=%0d/%0d exp=9/9", dut.r_head, dut.r_tail); end
    endtask

    task automatic test_overpop();
        cycle(1'b0, 1'b0, 2'b00, '0, 2'd0);
        cycle(1'b1, 1'b0, 2'b01, {8'h00, 8'h0A}, 2'd0);
        cycle(1'b1, 1'b0, 2'b11, {8'h0C, 8'h0B}, 2'd2);
        checks++; if (count !== 4'd2) begin errors++; $display("FAIL overpop_count got=%0d exp=2", count); end
        checks++; if (dut.r_head !== 4'd1) begin errors++; $display("FAIL overpop_head got=%0d exp=1", dut.r_head); end
        checks++; if (dequeue_data !== {8'h0C, 8'h0B}) begin errors++; $display("FAIL overpop_lanes got=%h exp=0c0b", dequeue_data); end
        cycle(1'b1, 1'b0, 2'b00, '0, 2'd3);
        checks++; if (empty !== 1'b1 || count !== 4'd0) begin errors++; $display("FAIL overpop_clamp got=%0d exp=0", count); end
    endtask

    task automatic test_flush();
        cycle(1'b0, 1'b0, 2'b00, '0, 2'd0);
        cycle(1'b1, 1'b0, 2'b11, {8'h42, 8'h41}, 2'd0);
        cycle(1'b1, 1'b0, 2'b11, {8'h44, 8'h43}, 2'd0);
        cycle(1'b1, 1'b0, 2'b01, {8'h00, 8'h45}, 2'd0);
        checks++; if (count !== 4'd5) begin errors++; $display("FAIL flush_pre got=%0d exp=5", count); end
        cycle(1'b1, 1'b1, 2'b11, {8'h47, 8'h46}, 2'd2);
        checks++; if (count !== 4'd0 || empty !== 1'b1) begin errors++; $display("FAIL flush_count got=%0d exp=0", count); end
        checks++; if (dequeue_valid !== 2'b00) begin errors++; $display("FAIL flush_valid got=%b exp=00", dequeue_valid); end
        cycle(1'b1, 1'b0, 2'b11, {8'h0F, 8'h0E}, 2'd0);
        checks++; if (dequeue_data !== {8'h0F, 8'h0E} || count !== 4'd2) begin errors++; $display("FAIL flush_after got=%h/%0d exp=0f0e/2", dequeue_data, count); end
    endtask

    task automatic test_random();
        int sz;
        cycle(1'b0, 1'b0, 2'b00, '0, 2'd0);
        for (int n = 0; n < 400; n++) begin
            cycle(($urandom_range(0, 63) != 0), ($urandom_range(0, 31) == 0),
                  2'($urandom), 16'($urandom), 2'($urandom));
            sz = m_q.size();
            checks++;
            if (count !== 4'(sz) || empty !== (sz == 0) || full !== (sz == DEPTH) ||
                enq_ready !== ((DEPTH - sz) >= 2) || get_data_req !== ((DEPTH - sz) >= 3) ||
                dequeue_valid !== {(sz > 1), (sz > 0)}) begin
                errors++;
                $display("FAIL rand_status n=%0d got cnt=%0d v=%b e=%b f=%b r=%b q=%b exp cnt=%0d", n,
                         count, dequeue_valid, empty, full, enq_ready, get_data_req, sz);
            end
            if (sz > 0) begin
                checks++;
                if (dequeue_data[DW-1:0] !== m_q[0]) begin errors++; $display("FAIL rand_lane0 n=%0d got=%h exp=%h", n, dequeue_data[DW-1:0], m_q[0]); end
            end
            if (sz > 1) begin
                checks++;
                if (dequeue_data[2*DW-1:DW] !== m_q[1]) begin errors++; $display("FAIL rand_lane1 n=%0d got=%h exp=%h", n, dequeue_data[2*DW-1:DW], m_q[1]); end
            end
        end
    endtask

    initial begin
        rst = 1'b0; flush = 1'b0; enqueue_en = '0; enqueue_data = '0; deq_num = '0;
        m_head = 0; m_tail = 0;
        test_reset();
        test_sparse();
        test_fill_backpressure();
        test_wrap();
        test_overpop();
        test_flush();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/multi_issue_fifo.md
Name: multi_issue_fifo

Overview:
- Parametrised N-in/M-out circular queue between fetch/decode and dispatch; successor to the fixed 2-wide decode queue.
- Accepts up to ENQ_W entries per cycle. Valid lanes may be sparse; they are compacted in lane order.
- Presents the oldest DEQ_W entries in order and retires 0..DEQ_W of them per cycle.
- Gives exact occupancy, all-or-nothing enqueue backpressure, and a threshold-based refill request.

Parameters:
- DATA_W, `DECODE_DATA_WIDTH, width of one entry.
- DEPTH, 16, number of entries; power of two, ≥ 2*max(ENQ_W,DEQ_W).
- ENQ_W, 2, enqueue lanes.
- DEQ_W, 2, dequeue lanes.
- REQ_THRESH, ENQ_W+1, minimum free slots for get_data_req to be asserted.

Ports:
- clk  in  1  clock, all state updates on posedge.
- rst  in  1  synchronous reset, active-low (rst==0 resets on posedge clk).
- flush  in  1  discard all contents.
- enqueue_en  in  ENQ_W  per-lane write valid.
- enqueue_data  in  ENQ_W*DATA_W  lane i at bits [i*DATA_W +: DATA_W].
- enq_ready  out  1  free slots ≥ ENQ_W.
- dequeue_valid  out  DEQ_W  bit i = (count > i).
- dequeue_data  out  DEQ_W*DATA_W  entry head+i at lane i.
- deq_num  in  clog2(DEQ_W+1)  number of entries retired this cycle.
- count  out  clog2(DEPTH+1)  occupied entries.
- get_data_req  out  1  (DEPTH−count) ≥ REQ_THRESH.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.

Behaviour:
- Pointers:
  - head and tail are clog2(DEPTH)+1 bits; the MSB is the wrap bit.
  - count = tail − head, taken modulo 2^(clog2(DEPTH)+1).
- Reset (rst==0) or flush:
  - head=tail=0 next cycle, count=0, empty=1, full=0, dequeue_valid=0.
  - enq_ready=1; get_data_req=1 (given REQ_THRESH ≤ DEPTH).
  - RAM contents are not cleared.
  - Reset has priority over flush, and flush over enqueue/dequeue in the same cycle. A coincident enq/deq is dropped.
- Enqueue:
  - Accepted only if enq_ready (registered count; no same-cycle pop credit).
  - Let k = popcount(enqueue_en). The j-th set lane, in ascending lane order, is written to ram[(tail+j) mod DEPTH].
  - tail advances by k.
  - If enq_ready=0, enqueue_en is ignored: no write, no pointer change.
  - Upstream must hold data until enq_ready.
- Dequeue:
  - dequeue_data lane i = ram[(head+i) mod DEPTH]. Combinational from head, zero added latency.
  - Lanes with dequeue_valid[i]=0 carry don't-care data.
  - head advances by min(deq_num, count). Over-pop is clamped, never underflows.
  - Entries must be consumed in order: deq_num=n retires lanes 0..n−1.
- Simultaneous enq and deq: both apply; count_next = count + k − min(deq_num,count).
  - With count=DEPTH, no enqueue occurs: enq_ready=0 holds even though deq_num>0 in that cycle.
- Latency:
  - A written entry is visible on dequeue_data the cycle after the enqueue edge.
  - No fall-through bypass on an empty queue.
- Wrap-around: index arithmetic is mod DEPTH; multi-lane writes and reads straddling slot DEPTH−1 → 0 must be correct.
- Outputs count/full/empty/enq_ready/get_data_req are derived only from registered pointers; no combinational path from inputs.

Test Plan:
- Reset: rst=0 for 2 cycles with enqueue_en=2'b11 → count=0, empty=1, enq_ready=1, get_data_req=1, dequeue_valid=00.
- Sparse compaction (DEPTH=8): enqueue_en=2'b10, data1=0xB → next cycle count=1, lane0=0xB. Then enqueue_en=2'b11 with data {0xD,0xC} → lane0=0xB, lane1=0xC, count=3.
- Fill/backpressure (DEPTH=8): enqueue pairs 1..6 → count=6, enq_ready=1, get_data_req=0 (free 2 < 3). Enqueue 7,8 → full=1, enq_ready=0. Further enqueue_en=11 is ignored and count stays 8. Then deq_num=2 with enqueue_en=11 → count=6, no write, lanes show 3,4.
- Wrap (DEPTH=8): with head=tail=7, enqueue {0x2,0x1} → ram[7]=0x1, ram[0]=0x2. Lanes read 0x1,0x2 in order; deq_num=2 → empty=1, head=tail=9 (mod 16).
- Over-pop and simultaneous: count=1, deq_num=2 with enqueue of 2 → count=2, head +1. Lanes show the two new entries.
- Flush priority: count=5, flush=1 together with enqueue_en=11 and deq_num=2 → next cycle count=0, empty=1. Entries enqueued the following cycle appear at lane0.
